// File: rtl/lf_cfg_ctrl_pkg.sv
// Shared definitions for the LF configuration controller.
// Opcodes, major-mode codes and the default SPI frame length.
package lf_cfg_ctrl_pkg;

    localparam int FRAME_W_DEF = 16;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_CONF      = 4'd1,
        OP_DIV       = 4'd2,
        OP_USER_BASE = 4'd3
    } lf_op_e;

    typedef enum logic [2:0] {
        LF_READ     = 3'b000,
        LF_EDGE     = 3'b001,
        LF_PASSTHRU = 3'b010,
        OFF_LF      = 3'b110,
        OFF         = 3'b111
    } lf_mode_e;

endpackage

// File: rtl/lf_cfg_ctrl_spi_frame_rx.sv
// SPI frame receiver in the pck0 domain: synchronisers, edge detect,
// shift register and a saturating bit counter.
module spi_frame_rx #(
    parameter int FRAME_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spck,
    input  logic               mosi,
    input  logic               ncs,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_vld,
    output logic               frame_bad
);

    localparam int CW = $clog2(FRAME_W + 2);

    logic [1:0]    spck_sync;
    logic [1:0]    mosi_sync;
    logic [1:0]    ncs_sync;
    logic          spck_q;
    logic          ncs_q;
    logic [CW-1:0] cnt;
    logic          spck_rise;
    logic          ncs_rise;
    logic          ncs_fall;

    // Two-flop synchronisers plus one delay stage for edge detection.
    // ncs resets high (idle) so leaving reset with the bus idle is not
    // mistaken for the end of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spck_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ncs_sync  <= 2'b11;
            spck_q    <= 1'b0;
            ncs_q     <= 1'b1;
        end else begin
            spck_sync <= {spck_sync[0], spck};
            mosi_sync <= {mosi_sync[0], mosi};
            ncs_sync  <= {ncs_sync[0], ncs};
            spck_q    <= spck_sync[1];
            ncs_q     <= ncs_sync[1];
        end
    end

    assign spck_rise = spck_sync[1] & ~spck_q;
    assign ncs_rise  = ncs_sync[1] & ~ncs_q;
    assign ncs_fall  = ~ncs_sync[1] & ncs_q;

    // Shift MSB-first data in; count bits, saturating one past a full
    // frame so overlong frames stay distinguishable from good ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame <= '0;
            cnt   <= '0;
        end else if (ncs_fall) begin
            cnt <= '0;
        end else if (spck_rise && !ncs_sync[1]) begin
            frame <= {frame[FRAME_W-2:0], mosi_sync[1]};
            if (cnt != CW'(FRAME_W + 1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign frame_vld = ncs_rise && (cnt == CW'(FRAME_W));
    assign frame_bad = ncs_rise && (cnt != CW'(FRAME_W));

endmodule

// File: rtl/lf_cfg_ctrl.sv
// LF configuration controller: register file, opcode decode and the
// guard FSM that parks major_mode at OFF across every mode change.
module lf_cfg_ctrl
    import lf_cfg_ctrl_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int NUM_USER   = 4,
    parameter int GUARD_CYC  = 16,
    parameter int DIV_RST    = 95,
    parameter int ED_THR_DEF = 127
) (
    input  logic                  pck0,
    input  logic                  rst,
    input  logic                  spck,
    input  logic                  mosi,
    input  logic                  ncs,
    output logic [7:0]            conf_word,
    output logic [2:0]            major_mode,
    output logic                  mode_active,
    output logic [7:0]            divisor,
    output logic [8*NUM_USER-1:0] user_bytes,
    output logic                  cfg_stb,
    output logic                  frame_err
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_GUARD = 1'b1;
    localparam int   GW       = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    logic [FRAME_W-1:0] frame;
    logic               frame_vld;
    logic               frame_bad;
    logic [3:0]         op;
    logic [7:0]         data;
    logic [3:0]         user_idx;
    logic               user_op;
    logic               wr_conf;
    logic               wr_div;
    logic               wr_user;
    logic               bad_op;
    logic               mode_chg;
    logic               state;
    logic [GW-1:0]      gcnt;
    logic               unused_frame;

    spi_frame_rx #(
        .FRAME_W (FRAME_W)
    ) u_rx (
        .clk       (pck0),
        .rst       (rst),
        .spck      (spck),
        .mosi      (mosi),
        .ncs       (ncs),
        .frame     (frame),
        .frame_vld (frame_vld),
        .frame_bad (frame_bad)
    );

    assign op           = frame[FRAME_W-1 -: 4];
    assign data         = frame[7:0];
    assign unused_frame = ^frame;
    assign user_idx     = op - OP_USER_BASE;
    assign user_op      = (op >= OP_USER_BASE) &&
                          (int'(op) < int'(OP_USER_BASE) + NUM_USER);
    assign mode_chg     = wr_conf && (data[7:5] != conf_word[7:5]);

    // Decode an accepted frame into exactly one write strobe or a reject.
    always_comb begin
        wr_conf = 1'b0;
        wr_div  = 1'b0;
        wr_user = 1'b0;
        bad_op  = 1'b0;
        if (frame_vld) begin
            unique case (1'b1)
                (op == OP_NOP):  ;
                (op == OP_CONF): wr_conf = 1'b1;
                (op == OP_DIV):  wr_div  = 1'b1;
                user_op:         wr_user = 1'b1;
                default:         bad_op  = 1'b1;
            endcase
        end
    end

    // Register file and one-cycle status strobes.
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            conf_word  <= 8'hE0;
            divisor    <= 8'(DIV_RST);
            user_bytes <= '0;
            cfg_stb    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cfg_stb   <= wr_conf | wr_div | wr_user;
            frame_err <= frame_bad | bad_op;
            if (wr_conf) begin
                conf_word <= data;
            end
            if (wr_conf && data == 8'h01) begin
                user_bytes[7:0] <= 8'(ED_THR_DEF);
            end
            if (wr_div) begin
                divisor <= data;
            end
            for (int k = 0; k < NUM_USER; k++) begin
                if (wr_user && int'(user_idx) == k) begin
                    user_bytes[8*k +: 8] <= data;
                end
            end
        end
    end

    // Guard FSM: any conf write that changes the mode, or any conf write
    // while already guarding, (re)starts the OFF interval.
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            gcnt  <= '0;
        end else if (state == ST_RUN) begin
            if (mode_chg) begin
                state <= ST_GUARD;
                gcnt  <= GW'(GUARD_CYC - 1);
            end
        end else begin
            if (wr_conf) begin
                gcnt <= GW'(GUARD_CYC - 1);
            end else if (gcnt == '0) begin
                state <= ST_RUN;
            end else begin
                gcnt <= gcnt - 1'b1;
            end
        end
    end

    assign major_mode  = (state == ST_GUARD) ? OFF : conf_word[7:5];
    assign mode_active = (state == ST_RUN);

endmodule

// File: tb/tb_lf_cfg_ctrl.sv
// Directed bench for lf_cfg_ctrl: vector table plus guard/reset sequences.
// A second instance with a long guard exercises the guard restart.
module tb_lf_cfg_ctrl;

    localparam int G2 = 200;

    logic        pck0 = 1'b0;
    logic        rst  = 1'b1;
    logic        spck = 1'b0;
    logic        mosi = 1'b0;
    logic        ncs  = 1'b1;

    logic [7:0]  conf_word;
    logic [2:0]  major_mode;
    logic        mode_active;
    logic [7:0]  divisor;
    logic [31:0] user_bytes;
    logic        cfg_stb;
    logic        frame_err;

    logic [7:0]  g_conf_word;
    logic [2:0]  g_major_mode;
    logic        g_mode_active;
    logic [7:0]  g_divisor;
    logic [31:0] g_user_bytes;
    logic        g_cfg_stb;
    logic        g_frame_err;

    int checks = 0;
    int errors = 0;
    int stb_total = 0;
    int err_total = 0;

    lf_cfg_ctrl dut (
        .pck0        (pck0),
        .rst         (rst),
        .spck        (spck),
        .mosi        (mosi),
        .ncs         (ncs),
        .conf_word   (conf_word),
        .major_mode  (major_mode),
        .mode_active (mode_active),
        .divisor     (divisor),
        .user_bytes  (user_bytes),
        .cfg_stb     (cfg_stb),
        .frame_err   (frame_err)
    );

    lf_cfg_ctrl #(
        .GUARD_CYC (G2)
    ) dut_g (
        .pck0        (pck0),
        .rst         (rst),
        .spck        (spck),
        .mosi        (mosi),
        .ncs         (ncs),
        .conf_word   (g_conf_word),
        .major_mode  (g_major_mode),
        .mode_active (g_mode_active),
        .divisor     (g_divisor),
        .user_bytes  (g_user_bytes),
        .cfg_stb     (g_cfg_stb),
        .frame_err   (g_frame_err)
    );

    always #5 pck0 = ~pck0;

    // Pulse counters for the default instance.
    always @(negedge pck0) begin
        if (cfg_stb)   stb_total = stb_total + 1;
        if (frame_err) err_total = err_total + 1;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] bits;
        int          nb;
        logic [7:0]  conf;
        logic [7:0]  div;
        logic [31:0] user;
        int          stb;
        int          err;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            repeat (2) @(negedge pck0);
            spck = 1'b1;
            repeat (2) @(negedge pck0);
            spck = 1'b0;
        end
    endtask

    task automatic close_frame(output bit s, output bit e);
        repeat (4) @(negedge pck0);
        ncs = 1'b1;
        s = 1'b0;
        e = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge pck0);
            if (cfg_stb || frame_err) begin
                s = cfg_stb;
                e = frame_err;
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] v, input int n,
                              output bit s, output bit e);
        ncs = 1'b0;
        repeat (4) @(negedge pck0);
        shift_bits(v, n);
        close_frame(s, e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_conf"}, conf_word, 8'hE0);
        chk({tag, "_major"}, major_mode, 3'b111);
        chk({tag, "_active"}, mode_active, 1'b1);
        chk({tag, "_div"}, divisor, 8'd95);
        chk({tag, "_user"}, user_bytes, 32'h0);
        chk({tag, "_g_major"}, g_major_mode, 3'b111);
        chk({tag, "_g_active"}, g_mode_active, 1'b1);
    endtask

    initial begin
        bit s, e;
        int s0, e0, n1, n2, offbad;

        vt[0] = '{32'h2058, 16, 8'hE0, 8'h58, 32'h0000_0000, 1, 0};
        vt[1] = '{32'h0000, 16, 8'hE0, 8'h58, 32'h0000_0000, 0, 0};
        vt[2] = '{32'h3A10, 16, 8'hE0, 8'h58, 32'h0000_0010, 1, 0};
        vt[3] = '{32'h5055, 16, 8'hE0, 8'h58, 32'h0055_0010, 1, 0};
        vt[4] = '{32'h1022, 15, 8'hE0, 8'h58, 32'h0055_0010, 0, 1};
        vt[5] = '{32'h12077, 17, 8'hE0, 8'h58, 32'h0055_0010, 0, 1};
        vt[6] = '{32'hF0AA, 16, 8'hE0, 8'h58, 32'h0055_0010, 0, 1};
        vt[7] = '{32'h7033, 16, 8'hE0, 8'h58, 32'h0055_0010, 0, 1};
        vt[8] = '{32'h6077, 16, 8'hE0, 8'h58, 32'h7755_0010, 1, 0};
        vt[9] = '{32'h10E5, 16, 8'hE5, 8'h58, 32'h7755_0010, 1, 0};

        repeat (3) @(negedge pck0);
        rst = 1'b0;
        repeat (3) @(negedge pck0);
        chk_reset("rst");
        chk("rst_stb", cfg_stb, 1'b0);
        chk("rst_err", frame_err, 1'b0);

        for (int i = 0; i < 10; i++) begin
            s0 = stb_total;
            e0 = err_total;
            send_frame(vt[i].bits, vt[i].nb, s, e);
            repeat (6) @(negedge pck0);
            chk($sformatf("v%0d_conf", i), conf_word, vt[i].conf);
            chk($sformatf("v%0d_div", i), divisor, vt[i].div);
            chk($sformatf("v%0d_user", i), user_bytes, vt[i].user);
            chk($sformatf("v%0d_stb", i), stb_total - s0, vt[i].stb);
            chk($sformatf("v%0d_err", i), err_total - e0, vt[i].err);
            chk($sformatf("v%0d_major", i), major_mode, 3'b111);
            chk($sformatf("v%0d_active", i), mode_active, 1'b1);
        end

        // conf 0x01: mode 111 -> 000 through a 16-cycle guard
        send_frame(32'h1001, 16, s, e);
        chk("c01_stb", s, 1'b1);
        chk("c01_conf", conf_word, 8'h01);
        chk("c01_user1", user_bytes, 32'h7755_007F);
        n1 = -1;
        offbad = 0;
        for (int k = 0; k < 40; k++) begin
            if (mode_active) begin
                n1 = k;
                break;
            end
            if (major_mode != 3'b111) offbad++;
            @(negedge pck0);
        end
        chk("c01_guard_len", n1, 16);
        chk("c01_guard_off", offbad, 0);
        chk("c01_major", major_mode, 3'b000);

        // conf 0x21: default instance is back in RUN, long-guard
        // instance is still guarding and must restart its count
        send_frame(32'h1021, 16, s, e);
        chk("c21_stb", s, 1'b1);
        chk("c21_g_inguard", g_mode_active, 1'b0);
        n1 = -1;
        n2 = -1;
        offbad = 0;
        for (int k = 0; k < 400; k++) begin
            if (n1 < 0 && mode_active) n1 = k;
            if (n2 < 0 && g_mode_active) n2 = k;
            if (n1 >= 0 && n2 >= 0) break;
            if (!g_mode_active && g_major_mode != 3'b111) offbad++;
            @(negedge pck0);
        end
        chk("c21_guard_len", n1, 16);
        chk("c21_restart_len", n2, G2);
        chk("c21_g_off", offbad, 0);
        chk("c21_major", major_mode, 3'b001);
        chk("c21_g_major", g_major_mode, 3'b001);
        chk("c21_g_conf", g_conf_word, 8'h21);

        // same-mode conf write stays in RUN
        send_frame(32'h1035, 16, s, e);
        chk("same_stb", s, 1'b1);
        chk("same_active", mode_active, 1'b1);
        chk("same_major", major_mode, 3'b001);

        // reset in the middle of a guard
        send_frame(32'h10C1, 16, s, e);
        repeat (3) @(negedge pck0);
        chk("mg_active", mode_active, 1'b0);
        chk("mg_major", major_mode, 3'b111);
        rst = 1'b1;
        #1;
        chk_reset("mg_rst");
        @(negedge pck0);
        rst = 1'b0;
        repeat (3) @(negedge pck0);
        chk_reset("mg_after");

        // reset in the middle of a frame: remainder is rejected
        e0 = err_total;
        s0 = stb_total;
        ncs = 1'b0;
        repeat (4) @(negedge pck0);
        shift_bits(32'h20, 8);
        rst = 1'b1;
        @(negedge pck0);
        rst = 1'b0;
        shift_bits(32'h58, 8);
        close_frame(s, e);
        repeat (6) @(negedge pck0);
        chk("mf_err", err_total - e0, 1);
        chk("mf_stb", stb_total - s0, 0);
        chk_reset("mf");

        // a good frame after all that still works
        send_frame(32'h2011, 16, s, e);
        repeat (4) @(negedge pck0);
        chk("post_div", divisor, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
